fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the instruction memory.
//  - Owns the PC; drives the combinational-read imem address/read enable.
//  - Captures each returned 32-bit word with its PC into a 2-entry buffer.
//  - Hands words to decode over a valid/ready handshake.
//  - Accepts redirects (branch/jump targets) from later stages.
// PARAMETERS
//  AWIDTH     32            address width
//  DWIDTH     32            instruction width
//  BASE_ADDR  32'h01000000  reset PC and base of the imem window
//  MEM_DEPTH  1<<20         imem window size in bytes; valid fetch range [BASE_ADDR, BASE_ADDR+MEM_DEPTH-4]
// PORTS
//  clk             in   1       clock
//  rst             in   1       reset; asynchronous, active-high
//  imem_addr_o     out  AWIDTH  fetch address to imem (= pc_q)
//  imem_read_en_o  out  1       imem read enable
//  imem_data_i     in   DWIDTH  imem read data, valid in the same cycle (combinational)
//  inst_valid_o    out  1       buffer head holds an instruction
//  inst_ready_i    in   1       decode accepts head this cycle
//  inst_o          out  DWIDTH  head instruction
//  inst_pc_o       out  AWIDTH  PC of head instruction
//  redirect_i      in   1       load new PC, flush buffer
//  redirect_pc_i   in   AWIDTH  redirect target
//  fetch_fault_o   out  1       sticky: misaligned target or PC outside imem window
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc_q=BASE_ADDR, count=0, fault=0.
//   - inst_valid_o=0, fetch_fault_o=0, imem_read_en_o=0 while rst=1; inst_o/inst_pc_o=0.
//  deq:
//   - deq = inst_valid_o & inst_ready_i.
//   - inst_valid_o = (count!=0); head is stable while valid & !ready.
//  fetch_ok:
//   - fetch_ok = !rst & !redirect_i & !fault & pc_in_range & (count<2 | deq).
//   - pc_in_range = BASE_ADDR <= pc_q <= BASE_ADDR+MEM_DEPTH-4, unsigned compare.
//   - imem_read_en_o = fetch_ok; imem_addr_o = pc_q always.
//  fetch_ok cycle:
//   - Enqueue {pc_q, imem_data_i}; pc_q <= pc_q+4 (mod 2^AWIDTH).
//   - Fetch-to-inst_valid_o latency is 1 cycle.
//   - Sustained throughput is 1 instr/cycle when decode is always ready.
//  Simultaneous enq+deq: count unchanged; FIFO order preserved.
//  Full (count=2) with no deq: no fetch; pc_q holds.
//  Redirect (has priority over everything except rst):
//   - count<=0 (head dropped even if deq this cycle; decode must ignore it).
//   - pc_q<=redirect_pc_i; no enqueue that cycle.
//   - If redirect_pc_i[1:0]!=0: fault<=1, pc_q<=redirect_pc_i.
//   - Otherwise fault<=0 (an aligned redirect clears the fault).
//  PC out of range with !fault and no redirect: fault<=1, no fetch.
//  While fault=1: no fetch; buffered entries still drain normally.
//  Reset mid-operation: buffer contents discarded immediately; pc_q=BASE_ADDR.
//  Implementation: state = pc_q, count[1:0], 2x{pc,insn} regs, fault.
// TESTING
//  1 rst 1->0, ready=1, imem word0=0x00500093 -> imem_addr 0x01000000; next cycle inst_valid=1, inst_o=0x00500093, inst_pc_o=0x01000000; PC then advances +4 per cycle.
//  2 ready=0 for 5 cycles -> exactly 2 entries (PC 0x01000000, 0x01000004) buffered, pc_q=0x01000008, read_en=0; ready=1 -> drained in order, no drop/dup.
//  3 redirect_i=1, redirect_pc_i=0x01000040 with 2 buffered -> next cycle inst_valid=0, imem_addr=0x01000040; one cycle later inst_pc_o=0x01000040.
//  4 redirect_pc_i=0x01000042 -> fetch_fault_o=1, read_en=0; later redirect 0x01000010 -> fault clears, fetch resumes at 0x01000010.
//  5 redirect to BASE_ADDR+MEM_DEPTH-4 -> that word is fetched, then fault=1 at BASE_ADDR+MEM_DEPTH with no further read_en.
//  6 assert rst mid-cycle with count=2 -> inst_valid_o and read_en drop immediately without a clock edge; after release fetch restarts at 0x01000000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - imem, decode-handshake and redirect signals of the fetch stage
// master is the fetch unit; slave is the surrounding imem/decode/branch logic.
interface fetch_unit_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  logic [AWIDTH-1:0] imem_addr_o;
  logic              imem_read_en_o;
  logic [DWIDTH-1:0] imem_data_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [DWIDTH-1:0] inst_o;
  logic [AWIDTH-1:0] inst_pc_o;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              fetch_fault_o;

  modport master (
    output imem_addr_o, imem_read_en_o, inst_valid_o, inst_o, inst_pc_o, fetch_fault_o,
    input  imem_data_i, inst_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_addr_o, imem_read_en_o, inst_valid_o, inst_o, inst_pc_o, fetch_fault_o,
    output imem_data_i, inst_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry output buffer
// Owns the PC, reads a combinational imem and hands {pc, insn} to decode.
module fetch_unit #(
  parameter int unsigned       AWIDTH    = 32,
  parameter int unsigned       DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000),
  parameter int unsigned       MEM_DEPTH = 1 << 20
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam logic [AWIDTH-1:0] LAST_ADDR = BASE_ADDR + AWIDTH'(MEM_DEPTH) - AWIDTH'(4);

  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  logic [AWIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [DWIDTH-1:0] insn0_q, insn0_d, insn1_q, insn1_d;
  logic              fault_q, fault_d;
  logic              pc_in_range;
  logic              deq;
  logic              fetch_ok;

  assign pc_in_range = (pc_q >= BASE_ADDR) && (pc_q <= LAST_ADDR);
  assign deq         = bus.inst_valid_o && bus.inst_ready_i;
  assign fetch_ok    = !rst && !bus.redirect_i && !fault_q && pc_in_range
                       && ((count_q < 2'd2) || deq);

  assign bus.imem_addr_o    = pc_q;
  assign bus.imem_read_en_o = fetch_ok;
  assign bus.inst_valid_o   = !rst && (count_q != 2'd0);
  assign bus.inst_o         = insn0_q;
  assign bus.inst_pc_o      = pc0_q;
  assign bus.fetch_fault_o  = fault_q;

  // Slot 0 is always the head; a dequeue shifts slot 1 down before the new word lands.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    insn0_d = insn0_q;
    insn1_d = insn1_q;
    fault_d = fault_q;
    if (bus.redirect_i) begin
      count_d = 2'd0;
      pc_d    = bus.redirect_pc_i;
      fault_d = |bus.redirect_pc_i[1:0];
    end else begin
      if (!fault_q && !pc_in_range) begin
        fault_d = 1'b1;
      end
      if (deq) begin
        pc0_d   = pc1_q;
        insn0_d = insn1_q;
      end
      if (fetch_ok) begin
        pc_d = pc_q + AWIDTH'(4);
        if ((count_q == 2'd0) || ((count_q == 2'd1) && deq)) begin
          pc0_d   = pc_q;
          insn0_d = bus.imem_data_i;
        end else begin
          pc1_d   = pc_q;
          insn1_d = bus.imem_data_i;
        end
      end
      count_d = count_q + {1'b0, fetch_ok} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= BASE_ADDR;
      count_q <= 2'd0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      insn0_q <= '0;
      insn1_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      insn0_q <= insn0_d;
      insn1_q <= insn1_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
// Reference model: a queue of {pc, insn} plus PC and fault flag, stepped once per clock.
module tb_fetch_unit;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] DEPTH = 32'h0010_0000;
  localparam logic [31:0] LAST  = BASE + DEPTH - 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready_r = 1'b1;
  logic        redir_r = 1'b0;
  logic [31:0] rpc_r = '0;
  int          tests = 0;
  int          fails = 0;

  logic [63:0] q[$];
  logic [31:0] m_pc = BASE;
  logic        m_fault = 1'b0;

  fetch_unit_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  fetch_unit #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_DEPTH(1 << 20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == BASE) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.imem_data_i   = mem_word(bus.imem_addr_o);
  assign bus.inst_ready_i  = ready_r;
  assign bus.redirect_i    = redir_r;
  assign bus.redirect_pc_i = rpc_r;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= LAST);
  endfunction

  function automatic logic exp_rd();
    return !rst && !redir_r && !m_fault && in_win(m_pc)
           && ((q.size() < 2) || ((q.size() > 0) && ready_r));
  endfunction

  function automatic logic [98:0] exp_vec();
    logic        v;
    logic [63:0] h;
    v = !rst && (q.size() > 0);
    h = v ? q[0] : 64'd0;
    return {v, exp_rd(), m_fault, m_pc, h[31:0], h[63:32]};
  endfunction

  function automatic logic [98:0] obs_vec();
    logic v;
    v = !rst && (q.size() > 0);
    return {bus.inst_valid_o, bus.imem_read_en_o, bus.fetch_fault_o, bus.imem_addr_o,
            v ? bus.inst_o : 32'd0, v ? bus.inst_pc_o : 32'd0};
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc    = BASE;
    m_fault = 1'b0;
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc);
    ready_r = r;
    redir_r = rd;
    rpc_r   = rpc;
    #1;
  endtask

  task automatic advance();
    logic d, en;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (redir_r) begin
      q.delete();
      m_pc    = rpc_r;
      m_fault = (rpc_r[1:0] != 2'b00);
    end else begin
      d  = (q.size() > 0) && ready_r;
      en = exp_rd();
      if (d) void'(q.pop_front());
      if (en) begin
        q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end else if (!m_fault && !in_win(m_pc)) begin
        m_fault = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({bus.inst_valid_o, bus.imem_read_en_o, bus.fetch_fault_o, bus.imem_addr_o, bus.inst_o, bus.inst_pc_o}
        !== {3'b000, BASE, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset got v=%b rd=%b f=%b a=%h i=%h p=%h want 0 0 0 %h 0 0", bus.inst_valid_o,
               bus.imem_read_en_o, bus.fetch_fault_o, bus.imem_addr_o, bus.inst_o, bus.inst_pc_o, BASE);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stream cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        tests++;
        if ({bus.inst_valid_o, bus.inst_o, bus.inst_pc_o} !== {1'b1, 32'h0050_0093, BASE}) begin
          fails++;
          $display("FAIL first_word got %b %h %h want 1 00500093 %h", bus.inst_valid_o, bus.inst_o, bus.inst_pc_o, BASE);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(i >= 5, 1'b0, 32'd0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL backpressure cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 5 || i == 6) begin
        tests++;
        if ({bus.inst_valid_o, bus.inst_pc_o} !== {1'b1, BASE + 32'(4 * (i - 5))}) begin
          fails++;
          $display("FAIL drain_order cyc%0d got %b %h want 1 %h", i, bus.inst_valid_o, bus.inst_pc_o, BASE + 32'(4 * (i - 5)));
        end
      end
      if (i == 4) begin
        tests++;
        if ({bus.imem_addr_o, bus.imem_read_en_o} !== {BASE + 32'd8, 1'b0}) begin
          fails++;
          $display("FAIL full_hold got %h %b want %h 0", bus.imem_addr_o, bus.imem_read_en_o, BASE + 32'd8);
        end
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, i == 3, 32'h0100_0040);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL redirect cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        tests++;
        if ({bus.inst_valid_o, bus.imem_addr_o} !== {1'b0, 32'h0100_0040}) begin
          fails++;
          $display("FAIL redirect_flush got %b %h want 0 01000040", bus.inst_valid_o, bus.imem_addr_o);
        end
      end
      if (i == 5) begin
        tests++;
        if ({bus.inst_valid_o, bus.inst_pc_o} !== {1'b1, 32'h0100_0040}) begin
          fails++;
          $display("FAIL redirect_target got %b %h want 1 01000040", bus.inst_valid_o, bus.inst_pc_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0 || i == 4, i == 0 ? 32'h0100_0042 : 32'h0100_0010);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL misaligned cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        tests++;
        if ({bus.fetch_fault_o, bus.imem_read_en_o} !== 2'b10) begin
          fails++;
          $display("FAIL fault_set got f=%b rd=%b want f=1 rd=0", bus.fetch_fault_o, bus.imem_read_en_o);
        end
      end
      if (i == 5) begin
        tests++;
        if ({bus.fetch_fault_o, bus.imem_read_en_o, bus.imem_addr_o} !== {2'b01, 32'h0100_0010}) begin
          fails++;
          $display("FAIL fault_clear got f=%b rd=%b a=%h want 0 1 01000010", bus.fetch_fault_o, bus.imem_read_en_o, bus.imem_addr_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_window_end();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i == 0, LAST);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL window_end cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
    tests++;
    if ({bus.fetch_fault_o, bus.imem_read_en_o, bus.imem_addr_o} !== {2'b10, BASE + DEPTH}) begin
      fails++;
      $display("FAIL window_fault got f=%b rd=%b a=%h want 1 0 %h", bus.fetch_fault_o, bus.imem_read_en_o, bus.imem_addr_o, BASE + DEPTH);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      advance();
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.inst_valid_o, bus.imem_read_en_o} !== 2'b00) begin
      fails++;
      $display("FAIL async_reset got v=%b rd=%b want 0 0", bus.inst_valid_o, bus.imem_read_en_o);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'd0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL reset_restart cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       t = BASE + (($urandom % DEPTH) & ~32'd3);
        1:       t = BASE + (($urandom % DEPTH) | 32'd1);
        2:       t = LAST - 32'(4 * $urandom_range(0, 3));
        default: t = 32'h0000_0100 + 32'(4 * $urandom_range(0, 15));
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, t);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_window_end();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
